// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, waits out the ROM
// latency, strobes the IR load for one cycle and applies absolute/relative jumps.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned INST_W  = 16,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_ld,
  input  logic              pc_rel,
  input  logic [ADDR_W-1:0] pc_val,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              ir_ld,
  output logic              busy,
  output logic              fetch_done,
  output logic [ADDR_W-1:0] pc_out
);

  if (ROM_LAT < 1 || ROM_LAT > 3 || INST_W == 0) begin : g_param_check
    $error("fetch_unit: ROM_LAT must be 1..3 and INST_W nonzero");
  end

  localparam logic [1:0] CntInit = 2'(ROM_LAT);

  typedef enum logic [1:0] {StIdle, StWait, StLoad} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fetch_done_q, fetch_done_d;
  logic              pend_fetch_q, pend_fetch_d;
  logic              pend_jmp_q, pend_jmp_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] jmp_addr;

  // Relative targets are resolved against the PC at capture time.
  assign jmp_addr = pc_rel ? pc_q + pc_val : pc_val;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    fetch_done_d = 1'b0;
    pend_fetch_d = pend_fetch_q;
    pend_jmp_d   = pend_jmp_q;
    pend_addr_d  = pend_addr_q;
    unique case (state_q)
      StIdle: begin
        if (pc_ld) begin
          // Jump first; a coincident fetch starts next cycle from the new PC.
          pc_d         = jmp_addr;
          pend_fetch_d = fetch_req | pend_fetch_q;
        end else if (fetch_req || pend_fetch_q) begin
          state_d      = StWait;
          cnt_d        = CntInit;
          pend_fetch_d = 1'b0;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = StLoad;
        end
        if (pc_ld) begin
          pend_jmp_d  = 1'b1;
          pend_addr_d = jmp_addr;
        end
      end
      StLoad: begin
        state_d      = StIdle;
        fetch_done_d = 1'b1;
        pend_jmp_d   = 1'b0;
        if (pc_ld) begin
          pc_d = jmp_addr;
        end else if (pend_jmp_q) begin
          pc_d = pend_addr_q;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      pc_q         <= '0;
      fetch_done_q <= 1'b0;
      pend_fetch_q <= 1'b0;
      pend_jmp_q   <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      fetch_done_q <= fetch_done_d;
      pend_fetch_q <= pend_fetch_d;
      pend_jmp_q   <= pend_jmp_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign rom_addr   = pc_q;
  assign pc_out     = pc_q;
  assign ir_ld      = (state_q == StLoad);
  assign busy       = (state_q != StIdle);
  assign fetch_done = fetch_done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetches/jumps push expected (IR, PC) pairs,
// monitors pop and compare on every fetch_done. Second instance covers ROM_LAT=3.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] ir;
    logic [6:0]  pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, reset3 = 1'b1;
  logic        fetch_req = 1'b0, pc_ld = 1'b0, pc_rel = 1'b0;
  logic [6:0]  pc_val = '0;
  logic        fetch_req3 = 1'b0, pc_ld3 = 1'b0;
  logic [6:0]  pc_val3 = '0;
  logic [6:0]  rom_addr, pc_out, rom_addr3, pc_out3;
  logic        ir_ld, busy, fetch_done, ir_ld3, busy3, fetch_done3;
  logic [15:0] rom [128];
  logic [15:0] ir = 16'h0000, ir3 = 16'h0000;
  exp_t        q1[$], q3[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(7), .INST_W(16), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_ld(pc_ld), .pc_rel(pc_rel),
    .pc_val(pc_val), .rom_addr(rom_addr), .ir_ld(ir_ld), .busy(busy),
    .fetch_done(fetch_done), .pc_out(pc_out)
  );

  fetch_unit #(.ADDR_W(7), .INST_W(16), .ROM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset3), .fetch_req(fetch_req3), .pc_ld(pc_ld3), .pc_rel(1'b0),
    .pc_val(pc_val3), .rom_addr(rom_addr3), .ir_ld(ir_ld3), .busy(busy3),
    .fetch_done(fetch_done3), .pc_out(pc_out3)
  );

  // Instruction registers as seen by the rest of the datapath.
  always @(posedge clk) begin
    if (ir_ld && !reset) ir <= rom[rom_addr];
    if (ir_ld3 && !reset3) ir3 <= rom[rom_addr3];
  end

  always @(negedge clk) begin
    exp_t e;
    if (fetch_done) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL mon1_unexpected: fetch_done with ir=%h pc=%0d, none expected", ir, pc_out);
      end else begin
        e = q1.pop_front();
        if (ir !== e.ir || pc_out !== e.pc) begin
          errors++;
          $display("FAIL mon1_fetch: got ir=%h pc=%0d expected ir=%h pc=%0d",
                   ir, pc_out, e.ir, e.pc);
        end
      end
    end
    if (fetch_done3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL mon3_unexpected: fetch_done with ir=%h pc=%0d, none expected", ir3, pc_out3);
      end else begin
        e = q3.pop_front();
        if (ir3 !== e.ir || pc_out3 !== e.pc) begin
          errors++;
          $display("FAIL mon3_fetch: got ir=%h pc=%0d expected ir=%h pc=%0d",
                   ir3, pc_out3, e.ir, e.pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drain1(input int budget);
    int n = 0;
    while (q1.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain1_timeout", q1.size(), 0);
    #1;
  endtask

  task automatic jump1(input logic [6:0] val, input logic rel);
    pc_ld = 1'b1; pc_rel = rel; pc_val = val;
    step();
    pc_ld = 1'b0; pc_rel = 1'b0;
  endtask

  task automatic fetch1();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 128; i++) rom[i] = 16'hFFFF ^ 16'(i);
    rom[0] = 16'h1234; rom[1] = 16'hBEEF; rom[2] = 16'hC0DE;
    rom[5] = 16'h0505; rom[10] = 16'h0A0A; rom[20] = 16'h1414; rom[127] = 16'h7F7F;

    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ir_ld", ir_ld, 0);
    chk("rst_fetch_done", fetch_done, 0);

    // Single fetch from reset: ir_ld only in cycle 2, done in cycle 3.
    step();
    q1.push_back('{ir: 16'h1234, pc: 7'd1});
    fetch_req = 1'b1;
    @(negedge clk);
    chk("t1_c0_busy", busy, 0);
    step(); fetch_req = 1'b0;
    @(negedge clk);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_ir_ld", ir_ld, 0);
    chk("t1_c1_addr", rom_addr, 0);
    step();
    @(negedge clk);
    chk("t1_c2_ir_ld", ir_ld, 1);
    chk("t1_c2_addr", rom_addr, 0);
    step();
    @(negedge clk);
    chk("t1_c3_done", fetch_done, 1);
    chk("t1_c3_busy", busy, 0);
    chk("t1_c3_ir_ld", ir_ld, 0);
    drain1(10);

    // Back-to-back: fetch_req held, accepted in every fetch_done cycle.
    jump1(7'd0, 1'b0);
    q1.push_back('{ir: 16'h1234, pc: 7'd1});
    q1.push_back('{ir: 16'hBEEF, pc: 7'd2});
    q1.push_back('{ir: 16'hC0DE, pc: 7'd3});
    fetch_req = 1'b1;
    repeat (7) step();
    fetch_req = 1'b0;
    drain1(20);

    // PC wrap and absolute jump.
    jump1(7'd127, 1'b0);
    @(negedge clk);
    chk("t3_pc_127", pc_out, 127);
    step();
    q1.push_back('{ir: 16'h7F7F, pc: 7'd0});
    fetch1();
    drain1(10);
    jump1(7'd10, 1'b0);
    @(negedge clk);
    chk("t3_pc_10", pc_out, 10);
    step();
    q1.push_back('{ir: 16'h0A0A, pc: 7'd11});
    fetch1();
    drain1(10);

    // Relative jump -2 during WAIT overrides the increment.
    jump1(7'd5, 1'b0);
    q1.push_back('{ir: 16'h0505, pc: 7'd3});
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0; pc_ld = 1'b1; pc_rel = 1'b1; pc_val = 7'h7E;
    step();
    pc_ld = 1'b0; pc_rel = 1'b0;
    drain1(10);

    // fetch_req with absolute jump in the same IDLE cycle.
    q1.push_back('{ir: 16'h1414, pc: 7'd21});
    fetch_req = 1'b1; pc_ld = 1'b1; pc_val = 7'd20;
    @(negedge clk);
    chk("t5_c0_busy", busy, 0);
    step();
    fetch_req = 1'b0; pc_ld = 1'b0;
    @(negedge clk);
    chk("t5_c1_busy", busy, 0);
    chk("t5_c1_addr", rom_addr, 20);
    step();
    @(negedge clk);
    chk("t5_c2_busy", busy, 1);
    drain1(10);

    // ROM_LAT=3: reset during LOAD aborts the fetch.
    reset3 = 1'b0;
    pc_ld3 = 1'b1; pc_val3 = 7'd9;
    step();
    pc_ld3 = 1'b0;
    fetch_req3 = 1'b1;
    step();
    fetch_req3 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ir_ld3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_load", ir_ld3, 1);
    reset3 = 1'b1;
    step();
    reset3 = 1'b0;
    @(negedge clk);
    chk("t6_rst_pc", pc_out3, 0);
    chk("t6_rst_busy", busy3, 0);
    chk("t6_rst_ir_ld", ir_ld3, 0);
    chk("t6_rst_done", fetch_done3, 0);
    step();
    @(negedge clk);
    chk("t6_no_late_done", fetch_done3, 0);

    // Fresh fetch completes after ROM_LAT+2 = 5 cycles.
    step();
    q3.push_back('{ir: 16'h1234, pc: 7'd1});
    fetch_req3 = 1'b1;
    step();
    fetch_req3 = 1'b0;
    n = 1;
    @(negedge clk);
    while (!fetch_done3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_latency", n, 5);
    step();
    chk("t6_q3_empty", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
